// File: rtl/bam_pkg.sv
// Shared constants, request type and partial-product keep rule for the
// broken-array multiplier scheduler.
package bam_pkg;

  localparam int BAM_WIDTH_DEF = 8;
  localparam int BAM_HCUT_DEF  = 5;
  localparam int BAM_VCUT_DEF  = 7;
  localparam int BAM_IDW_DEF   = 2;

  typedef struct packed {
    logic [BAM_WIDTH_DEF-1:0] a;
    logic [BAM_WIDTH_DEF-1:0] b;
    logic [BAM_IDW_DEF-1:0]   id;
  } bam_req_t;

  // Partial-product bit a[j]&b[i] survives only outside both cuts.
  function automatic logic bam_ppmask(input int i, input int j,
                                      input int hcut = BAM_HCUT_DEF,
                                      input int vcut = BAM_VCUT_DEF);
    return (i >= hcut) && ((i + j) >= vcut);
  endfunction

endpackage

// File: rtl/bam_mul_core.sv
// Combinational broken-array approximate multiplier: masked partial-product
// rows accumulated by a ripple chain of row adders.
module bam_mul_core
  import bam_pkg::*;
#(
  parameter int WIDTH = BAM_WIDTH_DEF,
  parameter int HCUT  = BAM_HCUT_DEF,
  parameter int VCUT  = BAM_VCUT_DEF
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] sum_s [WIDTH+1];

  assign sum_s[0] = '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [WIDTH-1:0]   keep_s;
    logic [2*WIDTH-1:0] row_s;
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
      assign keep_s[j] = bam_ppmask(i, j, HCUT, VCUT);
    end
    assign row_s        = {{WIDTH{1'b0}}, a & keep_s & {WIDTH{b[i]}}} << i;
    assign sum_s[i + 1] = sum_s[i] + row_s;
  end

  assign p = sum_s[WIDTH];

endmodule

// File: rtl/bam_mul_sched.sv
// Round-robin scheduler sharing one BAM multiplier among N_REQ requesters
// through a two-stage (operand, product) pipeline with a tagged response.
module bam_mul_sched
  import bam_pkg::*;
#(
  parameter int WIDTH = BAM_WIDTH_DEF,
  parameter int HCUT  = BAM_HCUT_DEF,
  parameter int VCUT  = BAM_VCUT_DEF,
  parameter int N_REQ = 4,
  parameter int IDW   = BAM_IDW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [2*WIDTH-1:0]     resp_out,
  output logic                   busy
);

  logic               v1_r;
  logic [WIDTH-1:0]   a1_r;
  logic [WIDTH-1:0]   b1_r;
  logic [IDW-1:0]     id1_r;
  logic [IDW-1:0]     ptr_r;

  logic               adv_s;
  logic               acc_s;
  logic               found_s;
  logic               xfer_s;
  logic [IDW-1:0]     win_s;
  logic [IDW-1:0]     ptr_nxt_s;
  logic [WIDTH-1:0]   a_sel_s;
  logic [WIDTH-1:0]   b_sel_s;
  logic [2*WIDTH-1:0] prod_s;

  assign adv_s = !resp_valid || resp_ready;
  assign acc_s = !v1_r || adv_s;

  // Scan from ptr_r upward (wrapping) for the first valid requester.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int o = 0; o < N_REQ; o++) begin
      if (!found_s && req_valid[(int'(ptr_r) + o) % N_REQ]) begin
        found_s = 1'b1;
        win_s   = IDW'((int'(ptr_r) + o) % N_REQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant the winner only while S1 can take it and reset is released.
  always_comb begin
    req_ready = '0;
    if (found_s && acc_s && rst_n) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign xfer_s    = |req_ready;
  assign ptr_nxt_s = IDW'((int'(win_s) + 1) % N_REQ);
  assign a_sel_s   = req_a[win_s*WIDTH +: WIDTH];
  assign b_sel_s   = req_b[win_s*WIDTH +: WIDTH];
  assign busy      = v1_r | resp_valid;

  bam_mul_core #(
    .WIDTH (WIDTH),
    .HCUT  (HCUT),
    .VCUT  (VCUT)
  ) u_core (
    .a (a1_r),
    .b (b1_r),
    .p (prod_s)
  );

  // Operand capture; contents are qualified by v1_r so no reset is needed.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      a1_r  <= a_sel_s;
      b1_r  <= b_sel_s;
      id1_r <= win_s;
    end else begin
      a1_r  <= a1_r;
      b1_r  <= b1_r;
      id1_r <= id1_r;
    end
  end

  // Control state: priority pointer, S1 valid and the S2 response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r      <= '0;
      v1_r       <= 1'b0;
      resp_valid <= 1'b0;
      resp_out   <= '0;
      resp_id    <= '0;
    end else begin
      if (xfer_s) begin
        ptr_r <= ptr_nxt_s;
        v1_r  <= 1'b1;
      end else if (adv_s) begin
        v1_r  <= 1'b0;
      end else begin
        v1_r  <= v1_r;
      end
      if (adv_s) begin
        resp_valid <= v1_r;
      end else begin
        resp_valid <= resp_valid;
      end
      // Data only moves with a real transaction so an empty slot keeps old values.
      if (adv_s && v1_r) begin
        resp_out <= prod_s;
        resp_id  <= id1_r;
      end else begin
        resp_out <= resp_out;
        resp_id  <= resp_id;
      end
    end
  end

endmodule

// File: tb/tb_bam_mul_sched.sv
// Bench for bam_mul_sched: directed scenarios plus a randomized run checked
// against a queue-based model of a 2-deep round-robin multiplier service.
module tb_bam_mul_sched;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int HC  = 5;
  localparam int VC  = 7;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic           resp_valid;
  logic           resp_ready = 1'b0;
  logic [IDW-1:0] resp_id;
  logic [2*W-1:0] resp_out;
  logic           busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           id;
    logic [15:0]  p;
    int           e;
  } item_t;

  always #5 clk = ~clk;

  bam_mul_sched #(.WIDTH(W), .HCUT(HC), .VCUT(VC), .N_REQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_out(resp_out), .busy(busy)
  );

  function automatic logic [15:0] bam_ref(input logic [7:0] a, input logic [7:0] b);
    int unsigned s = 0;
    for (int i = HC; i < W; i++)
      for (int j = 0; j < W; j++)
        if ((i + j) >= VC && a[j] && b[i]) s += (32'd1 << (i + j));
    return s[15:0];
  endfunction

  task automatic set_req(input int k, input logic v, input logic [7:0] a, input logic [7:0] b);
    req_valid[k]   = v;
    req_a[k*W +: W] = a;
    req_b[k*W +: W] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%h want=0", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_rv got=%b want=0", resp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({resp_id, resp_out} !== 18'd0) begin bad++; $display("FAIL reset_data got=%0d/%0d want=0/0", resp_id, resp_out); end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_req(0, 1'b1, 8'd255, 8'd255); resp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL basic_grant got=%b want=0001", req_ready); end
    next_cyc();
    set_req(0, 1'b0, 8'd0, 8'd0);
    #1;
    total++; if ({resp_valid, busy, req_ready} !== 6'b010000) begin bad++; $display("FAIL basic_s1 got rv=%b busy=%b rdy=%b want 0 1 0000", resp_valid, busy, req_ready); end
    next_cyc(); #1;
    total++; if ({resp_valid, resp_id, resp_out} !== {1'b1, 2'd0, 16'd56960}) begin bad++; $display("FAIL basic_result got rv=%b id=%0d out=%0d want 1 0 56960", resp_valid, resp_id, resp_out); end
    next_cyc(); #1;
    total++; if ({resp_valid, busy} !== 2'b00) begin bad++; $display("FAIL basic_idle got rv=%b busy=%b want 0 0", resp_valid, busy); end
  endtask

  task automatic test_boundary();
    logic [7:0]  ta [4] = '{8'd3, 8'd4, 8'd0, 8'd128};
    logic [7:0]  tb [4] = '{8'd32, 8'd32, 8'd255, 8'd128};
    logic [15:0] te [4] = '{16'd0, 16'd128, 16'd0, 16'd16384};
    resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      set_req(0, 1'b1, ta[t], tb[t]);
      next_cyc();
      set_req(0, 1'b0, 8'd0, 8'd0);
      next_cyc(); #1;
      total++; if ({resp_valid, resp_out} !== {1'b1, te[t]}) begin bad++; $display("FAIL boundary_%0d got rv=%b out=%0d want 1 %0d", t, resp_valid, resp_out, te[t]); end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0]  ea [N];
    logic [7:0]  eb [N];
    logic [15:0] gp [10];
    logic [N-1:0] er;
    do_reset();
    resp_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      ea[k] = 8'($urandom); eb[k] = 8'($urandom); set_req(k, 1'b1, ea[k], eb[k]);
    end
    for (int c = 0; c < 11; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      er = (c < 8) ? N'(1 << (c % N)) : '0;
      total++; if (req_ready !== er) begin bad++; $display("FAIL rr_grant_%0d got=%b want=%b", c, req_ready, er); end
      if (c >= 2 && c < 10) begin
        total++; if ({resp_valid, resp_id, resp_out} !== {1'b1, IDW'((c - 2) % N), gp[c-2]})
          begin bad++; $display("FAIL rr_result_%0d got rv=%b id=%0d out=%0d want 1 %0d %0d", c, resp_valid, resp_id, resp_out, (c - 2) % N, gp[c-2]); end
      end else begin
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rr_empty_%0d got rv=%b want 0", c, resp_valid); end
      end
      if (c < 8) gp[c] = bam_ref(ea[c % N], eb[c % N]);
      next_cyc();
      if (c < 8) begin
        ea[c % N] = 8'($urandom); eb[c % N] = 8'($urandom);
        set_req(c % N, 1'b1, ea[c % N], eb[c % N]);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0]  a [3];
    logic [7:0]  b [3];
    logic [15:0] p [3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      a[k] = 8'($urandom_range(32, 255)); b[k] = 8'($urandom_range(32, 255)); p[k] = bam_ref(a[k], b[k]);
    end
    set_req(0, 1'b1, a[0], b[0]);
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL stall_g0 got=%b want=0001", req_ready); end
    next_cyc();
    set_req(0, 1'b0, 8'd0, 8'd0); set_req(1, 1'b1, a[1], b[1]);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_g1 got=%b want=0010", req_ready); end
    next_cyc();
    set_req(1, 1'b0, 8'd0, 8'd0); set_req(2, 1'b1, a[2], b[2]);
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if ({req_ready, busy, resp_valid, resp_id, resp_out} !== {4'b0000, 1'b1, 1'b1, 2'd0, p[0]})
        begin bad++; $display("FAIL stall_hold_%0d got rdy=%b busy=%b rv=%b id=%0d out=%0d want 0000 1 1 0 %0d", c, req_ready, busy, resp_valid, resp_id, resp_out, p[0]); end
      next_cyc();
    end
    resp_ready = 1'b1;
    #1;
    total++; if ({req_ready, resp_valid, resp_id} !== {4'b0100, 1'b1, 2'd0}) begin bad++; $display("FAIL stall_release got rdy=%b rv=%b id=%0d want 0100 1 0", req_ready, resp_valid, resp_id); end
    next_cyc();
    set_req(2, 1'b0, 8'd0, 8'd0);
    for (int k = 1; k < 3; k++) begin
      #1;
      total++; if ({resp_valid, resp_id, resp_out} !== {1'b1, IDW'(k), p[k]}) begin bad++; $display("FAIL stall_drain_%0d got rv=%b id=%0d out=%0d want 1 %0d %0d", k, resp_valid, resp_id, resp_out, k, p[k]); end
      next_cyc();
    end
    #1;
    total++; if ({resp_valid, busy} !== 2'b00) begin bad++; $display("FAIL stall_nodup got rv=%b busy=%b want 0 0", resp_valid, busy); end
  endtask

  task automatic test_ptr_skip();
    do_reset();
    resp_ready = 1'b1;
    set_req(1, 1'b1, 8'd200, 8'd100);
    next_cyc();
    set_req(1, 1'b0, 8'd0, 8'd0);
    next_cyc(); next_cyc();
    set_req(1, 1'b1, 8'd10, 8'd20); set_req(3, 1'b1, 8'd30, 8'd40);
    #1;
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL skip_first got=%b want=1000", req_ready); end
    next_cyc();
    set_req(3, 1'b0, 8'd0, 8'd0);
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL skip_second got=%b want=0010", req_ready); end
    next_cyc();
    set_req(1, 1'b0, 8'd0, 8'd0);
    #1;
    total++; if ({resp_valid, resp_id} !== {1'b1, 2'd3}) begin bad++; $display("FAIL skip_resp3 got rv=%b id=%0d want 1 3", resp_valid, resp_id); end
    next_cyc(); #1;
    total++; if ({resp_valid, resp_id} !== {1'b1, 2'd1}) begin bad++; $display("FAIL skip_resp1 got rv=%b id=%0d want 1 1", resp_valid, resp_id); end
    next_cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 8'd77, 8'd99);
    next_cyc();
    set_req(0, 1'b0, 8'd0, 8'd0); set_req(1, 1'b1, 8'd55, 8'd66);
    next_cyc();
    req_valid = 4'b0110;
    #1;
    total++; if ({req_ready, busy, resp_valid} !== 6'b000011) begin bad++; $display("FAIL midrst_full got rdy=%b busy=%b rv=%b want 0000 1 1", req_ready, busy, resp_valid); end
    #1 rst_n = 1'b0;
    #1;
    total++; if ({req_ready, busy, resp_valid} !== 6'b000000) begin bad++; $display("FAIL midrst_drop got rdy=%b busy=%b rv=%b want 0000 0 0", req_ready, busy, resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL midrst_grant got=%b want=0010", req_ready); end
    next_cyc();
    req_valid = '0; resp_ready = 1'b1;
    next_cyc(); #1;
    total++; if ({resp_valid, resp_id} !== {1'b1, 2'd1}) begin bad++; $display("FAIL midrst_resp got rv=%b id=%0d want 1 1", resp_valid, resp_id); end
    next_cyc();
  endtask

  task automatic test_random();
    logic        va [N];
    logic [7:0]  aa [N];
    logic [7:0]  ba [N];
    item_t       q [$];
    item_t       it;
    int          ptr_m = 0;
    int          edge_cnt = 0;
    int          win;
    logic [N-1:0] er;
    logic        erv;
    do_reset();
    for (int k = 0; k < N; k++) va[k] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!va[k] && $urandom_range(0, 1) == 1) begin
          va[k] = 1'b1; aa[k] = 8'($urandom); ba[k] = 8'($urandom);
        end
        set_req(k, va[k], aa[k], ba[k]);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      win = -1;
      for (int o = 0; o < N; o++)
        if (win < 0 && va[(ptr_m + o) % N]) win = (ptr_m + o) % N;
      er  = (win >= 0 && (q.size() < 2 || resp_ready)) ? N'(1 << win) : '0;
      erv = (q.size() > 0) && (edge_cnt >= q[0].e + 1);
      total++; if (req_ready !== er) begin bad++; $display("FAIL rand_ready_%0d got=%b want=%b", c, req_ready, er); end
      total++; if (busy !== (q.size() > 0)) begin bad++; $display("FAIL rand_busy_%0d got=%b want=%b", c, busy, q.size() > 0); end
      total++; if (resp_valid !== erv) begin bad++; $display("FAIL rand_rv_%0d got=%b want=%b", c, resp_valid, erv); end
      if (erv) begin
        total++; if ({resp_id, resp_out} !== {IDW'(q[0].id), q[0].p}) begin bad++; $display("FAIL rand_data_%0d got id=%0d out=%0d want %0d %0d", c, resp_id, resp_out, q[0].id, q[0].p); end
      end
      @(posedge clk);
      edge_cnt++;
      if (erv && resp_ready) void'(q.pop_front());
      if (er != '0) begin
        it.id = win; it.p = bam_ref(aa[win], ba[win]); it.e = edge_cnt;
        q.push_back(it);
        ptr_m = (win + 1) % N;
        va[win] = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_round_robin();
    test_stall();
    test_ptr_skip();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
